// File: rtl/ysyx_22050133_pkg.sv
// Shared encodings for the memory arbiter: FSM states and transaction owner.
package ysyx_22050133_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22050133_arb_pick.sv
// Two-way grant selection: LS wins when it has priority or IF is idle.
module ysyx_22050133_arb_pick (
  input  logic en_i,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  input  logic prio_ls_i,
  output logic grant_if_o,
  output logic grant_ls_o
);

  assign grant_ls_o = en_i & ls_valid_i & (prio_ls_i | ~if_valid_i);
  assign grant_if_o = en_i & if_valid_i & ~grant_ls_o;

endmodule

// File: rtl/ysyx_22050133_mem_arb.sv
// IF/LS to single memory port arbiter, one outstanding transaction.
// Define YSYX_22050133_ARB_RR_EN for round-robin on simultaneous requests.
module ysyx_22050133_mem_arb
  import ysyx_22050133_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_resp_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_resp_valid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a request transfers on the cycle where valid & ready are both 1;
  // ready never waits on valid beyond the arbitration decision, and responses
  // are single-cycle pulses with no back-pressure.
  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;

  logic in_idle, grant_if, grant_ls, accept, resp_hit, prio_ls;

  assign in_idle = (state_q == ST_IDLE) & ~rst;

`ifdef YSYX_22050133_ARB_RR_EN
  // After a grant the other side gets priority; reset favours LS.
  logic rr_ls_q;
  always_ff @(posedge clk) begin
    if (rst)         rr_ls_q <= 1'b1;
    else if (accept) rr_ls_q <= grant_if;
  end
  assign prio_ls = rr_ls_q;
`else
  assign prio_ls = 1'b1;
`endif

  ysyx_22050133_arb_pick u_pick (
    .en_i       (in_idle),
    .if_valid_i (if_req_valid),
    .ls_valid_i (ls_req_valid),
    .prio_ls_i  (prio_ls),
    .grant_if_o (grant_if),
    .grant_ls_o (grant_ls)
  );

  assign accept   = grant_if | grant_ls;
  assign resp_hit = (state_q == ST_WAIT) & mem_resp_valid & ~rst;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          owner_d = grant_ls ? OWN_LS : OWN_IF;
          addr_d  = grant_ls ? ls_addr : if_addr;
          wen_d   = grant_ls & ls_wen;
          wdata_d = grant_ls ? ls_wdata : '0;
          wmask_d = grant_ls ? ls_wmask : '0;
        end
      end
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_resp_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flushed fetch still consumes its response, but silently.
    if (state_q != ST_IDLE && owner_q == OWN_IF && if_flush) drop_d = 1'b1;
    if (state_d == ST_IDLE) drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign if_resp_valid = resp_hit & (owner_q == OWN_IF) & ~drop_q & ~if_flush;
  assign ls_resp_valid = resp_hit & (owner_q == OWN_LS);
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

  assign mem_req_valid = (state_q == ST_REQ) & ~rst;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign dbg_state_o   = state_q;

endmodule
